// File: rtl/uart_reg_master_if.sv
// Command/response bus between the on-chip command source and uart_reg_master.
interface uart_reg_master_if #(
   parameter int unsigned DATA_BYTES = 1
);
   localparam int unsigned CMD_W = 8 + 8 * DATA_BYTES;
   localparam int unsigned DAT_W = 8 * DATA_BYTES;

   logic [CMD_W-1:0] cmd_in;
   logic             cmd_vld;
   logic             cmd_rdy;
   logic [DAT_W-1:0] rd_data;
   logic             rd_vld;
   logic             rd_err;
   logic             wr_done;

   modport master (output cmd_in, cmd_vld, input cmd_rdy, rd_data, rd_vld, rd_err, wr_done);
   modport slave  (input cmd_in, cmd_vld, output cmd_rdy, rd_data, rd_vld, rd_err, wr_done);
endinterface

// File: rtl/uart_reg_master.sv
// UART register-access master: header + payload frames on tx, reply bytes on rx.
// Optional rx start-bit timeout enabled by macro UART_RX_TIMEOUT_EN.
module uart_reg_master #(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned DATA_BYTES = 1,
   parameter int unsigned PARITY     = 1,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned GAP_BITS   = 2,
   parameter int unsigned RX_TIMEOUT = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_reg_master_if.slave bus,
   input  logic             rx,
   output logic             tx
);
   localparam int unsigned DAT_W = 8 * DATA_BYTES;
   localparam int unsigned CMD_W = 8 + DAT_W;
   localparam int unsigned CYC_W = $clog2(CLK_DIV);
   localparam logic [CYC_W-1:0] CYC_END = CYC_W'(CLK_DIV - 1);
   localparam logic [CYC_W-1:0] CYC_MID = CYC_W'(CLK_DIV / 2 - 1);

   // Reject unsupported configurations at elaboration.
   if (CLK_DIV < 4 || DATA_BYTES < 1 || DATA_BYTES > 4 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || GAP_BITS > 15 || RX_TIMEOUT < 1) begin : g_bad_param
      $error("uart_reg_master: unsupported parameter value");
   end

   typedef enum logic [3:0] {
      IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_GAP,
      RX_WAIT, RX_DATA, RX_PAR, RX_STOP, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CYC_W-1:0] cyc, cyc_nxt;
   logic [3:0]       idx, idx_nxt;
   logic [2:0]       byte_idx, byte_nxt;
   logic             is_wr, is_wr_nxt;
   logic [7:0]       tx_byte, tx_byte_nxt;
   logic [DAT_W-1:0] data_sh, data_sh_nxt;
   logic [7:0]       rx_byte, rx_byte_nxt;
   logic [DAT_W-1:0] rd_sh, rd_sh_nxt;
   logic             err, err_nxt, err_now;
   logic             started, started_nxt;
   logic             rx_s1, rx_s2, rx_d;
   logic             tx_nxt, rdy_nxt, rd_vld_nxt, rd_err_nxt, wr_done_nxt;
   logic [DAT_W-1:0] rd_data_nxt;
   logic             cmd_rdy, rd_vld, rd_err, wr_done;
   logic [DAT_W-1:0] rd_data;
   logic [2:0]       nbit;
   logic             cyc_end, accept, tx_last, to_exp;

   assign cyc_end = (cyc == CYC_END);
   assign accept  = bus.cmd_vld && cmd_rdy;
   assign tx_last = !is_wr || (byte_idx == 3'(DATA_BYTES));

`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TO_MAX = RX_TIMEOUT * CLK_DIV;
   localparam int unsigned TO_W   = $clog2(TO_MAX + 1);
   logic [TO_W-1:0] to_cnt, to_nxt;
   assign to_exp = !started && (to_cnt == TO_W'(TO_MAX - 1));
`else
   assign to_exp = 1'b0;
`endif

   assign bus.cmd_rdy = cmd_rdy;
   assign bus.rd_data = rd_data;
   assign bus.rd_vld  = rd_vld;
   assign bus.rd_err  = rd_err;
   assign bus.wr_done = wr_done;

   function automatic logic par_of(input logic [7:0] b);
      return (^b) ^ (PARITY == 2);
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = TX_START;
         TX_START: if (cyc_end) state_nxt = TX_DATA;
         TX_DATA:  if (cyc_end && idx == 4'd7) state_nxt = (PARITY != 0) ? TX_PAR : TX_STOP;
         TX_PAR:   if (cyc_end) state_nxt = TX_STOP;
         TX_STOP:
            if (cyc_end && idx == 4'(STOP_BITS - 1)) begin
               if (tx_last)            state_nxt = is_wr ? DONE : RX_WAIT;
               else if (GAP_BITS != 0) state_nxt = TX_GAP;
               else                    state_nxt = TX_START;
            end
         TX_GAP:   if (cyc_end && idx == 4'(GAP_BITS - 1)) state_nxt = TX_START;
         RX_WAIT:
            if (to_exp) state_nxt = DONE;
            else if (started && cyc == CYC_MID && !rx_s2) state_nxt = RX_DATA;
         RX_DATA:  if (cyc_end && idx == 4'd7) state_nxt = (PARITY != 0) ? RX_PAR : RX_STOP;
         RX_PAR:   if (cyc_end) state_nxt = RX_STOP;
         RX_STOP:
            if (cyc_end && idx == 4'(STOP_BITS - 1))
               state_nxt = (byte_idx == 3'(DATA_BYTES - 1)) ? DONE : RX_WAIT;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      tx_nxt      = tx;
      rdy_nxt     = cmd_rdy;
      rd_data_nxt = rd_data;
      rd_err_nxt  = rd_err;
      rd_vld_nxt  = 1'b0;
      wr_done_nxt = 1'b0;
      cyc_nxt     = cyc_end ? '0 : cyc + CYC_W'(1);
      idx_nxt     = idx;
      byte_nxt    = byte_idx;
      is_wr_nxt   = is_wr;
      tx_byte_nxt = tx_byte;
      data_sh_nxt = data_sh;
      rx_byte_nxt = rx_byte;
      rd_sh_nxt   = rd_sh;
      err_nxt     = err;
      err_now     = err;
      started_nxt = 1'b0;
      nbit        = 3'(idx + 4'd1);
`ifdef UART_RX_TIMEOUT_EN
      to_nxt      = '0;
`endif
      case (state)
         IDLE: begin
            cyc_nxt = '0;
            if (accept) begin
               rdy_nxt     = 1'b0;
               tx_nxt      = 1'b0;
               is_wr_nxt   = bus.cmd_in[CMD_W-1];
               tx_byte_nxt = bus.cmd_in[CMD_W-1 -: 8];
               data_sh_nxt = bus.cmd_in[DAT_W-1:0];
               byte_nxt    = '0;
               idx_nxt     = '0;
               err_nxt     = 1'b0;
            end
         end
         TX_START:
            if (cyc_end) begin
               idx_nxt = '0;
               tx_nxt  = tx_byte[0];
            end
         TX_DATA:
            if (cyc_end) begin
               if (idx == 4'd7) begin
                  idx_nxt = '0;
                  tx_nxt  = (PARITY != 0) ? par_of(tx_byte) : 1'b1;
               end else begin
                  idx_nxt = idx + 4'd1;
                  tx_nxt  = tx_byte[nbit];
               end
            end
         TX_PAR:
            if (cyc_end) begin
               idx_nxt = '0;
               tx_nxt  = 1'b1;
            end
         TX_STOP:
            if (cyc_end) begin
               if (idx == 4'(STOP_BITS - 1)) begin
                  idx_nxt = '0;
                  if (tx_last) begin
                     wr_done_nxt = is_wr;
                  end else begin
                     tx_byte_nxt = data_sh[7:0];
                     data_sh_nxt = data_sh >> 8;
                     byte_nxt    = byte_idx + 3'd1;
                     tx_nxt      = (GAP_BITS != 0);
                  end
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
         TX_GAP:
            if (cyc_end) begin
               if (idx == 4'(GAP_BITS - 1)) begin
                  idx_nxt = '0;
                  tx_nxt  = 1'b0;
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
         RX_WAIT: begin
`ifdef UART_RX_TIMEOUT_EN
            to_nxt = to_cnt + TO_W'(1);
`endif
            if (to_exp) begin
               rd_vld_nxt  = 1'b1;
               rd_err_nxt  = 1'b1;
               rd_data_nxt = '0;
            end else if (!started) begin
               cyc_nxt     = '0;
               started_nxt = rx_d && !rx_s2;
            end else if (cyc == CYC_MID) begin
               // A start still low at mid-bit is genuine; otherwise re-arm.
               cyc_nxt = '0;
               idx_nxt = '0;
            end else begin
               started_nxt = 1'b1;
            end
         end
         RX_DATA:
            if (cyc_end) begin
               rx_byte_nxt = {rx_s2, rx_byte[7:1]};
               idx_nxt     = (idx == 4'd7) ? 4'd0 : idx + 4'd1;
            end
         RX_PAR:
            if (cyc_end) begin
               idx_nxt = '0;
               if (rx_s2 != par_of(rx_byte)) err_nxt = 1'b1;
            end
         RX_STOP:
            if (cyc_end) begin
               err_now = err | !rx_s2;
               err_nxt = err_now;
               if (idx == 4'(STOP_BITS - 1)) begin
                  idx_nxt   = '0;
                  rd_sh_nxt = DAT_W'({rx_byte, rd_sh} >> 8);
                  if (byte_idx == 3'(DATA_BYTES - 1)) begin
                     rd_vld_nxt  = 1'b1;
                     rd_err_nxt  = err_now;
                     rd_data_nxt = rd_sh_nxt;
                  end else begin
                     byte_nxt = byte_idx + 3'd1;
                  end
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
         DONE: begin
            cyc_nxt = '0;
            rdy_nxt = 1'b1;
            tx_nxt  = 1'b1;
         end
         default: begin
            cyc_nxt = '0;
            tx_nxt  = 1'b1;
         end
      endcase
   end

   // Datapath, synchroniser and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc      <= '0;
         idx      <= '0;
         byte_idx <= '0;
         is_wr    <= 1'b0;
         tx_byte  <= '0;
         data_sh  <= '0;
         rx_byte  <= '0;
         rd_sh    <= '0;
         err      <= 1'b0;
         started  <= 1'b0;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         tx       <= 1'b1;
         cmd_rdy  <= 1'b1;
         rd_data  <= '0;
         rd_vld   <= 1'b0;
         rd_err   <= 1'b0;
         wr_done  <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
         to_cnt   <= '0;
`endif
      end else begin
         cyc      <= cyc_nxt;
         idx      <= idx_nxt;
         byte_idx <= byte_nxt;
         is_wr    <= is_wr_nxt;
         tx_byte  <= tx_byte_nxt;
         data_sh  <= data_sh_nxt;
         rx_byte  <= rx_byte_nxt;
         rd_sh    <= rd_sh_nxt;
         err      <= err_nxt;
         started  <= started_nxt;
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_d     <= rx_s2;
         tx       <= tx_nxt;
         cmd_rdy  <= rdy_nxt;
         rd_data  <= rd_data_nxt;
         rd_vld   <= rd_vld_nxt;
         rd_err   <= rd_err_nxt;
         wr_done  <= wr_done_nxt;
`ifdef UART_RX_TIMEOUT_EN
         to_cnt   <= to_nxt;
`endif
      end
   end
endmodule
